voice_allocator: RTL and testbench

Polyphony controller for the piano tone path. Scans the 13 debounced keyboard keys and assigns each pressed key to one of NUM_VOICES sine-ROM voice channels. Frees a voice when its key is released, and steals the least-recently-allocated voice when all voices are busy. Sits between the key debouncer and the speaker datapath, and replaces ad-hoc per-ROM key selection with one registered arbitration point.

---
 rtl/voice_allocator_pkg.sv | 39 +++
 rtl/voice_allocator_if.sv | 26 ++
 rtl/voice_allocator_lru.sv | 79 +++++++
 rtl/voice_allocator.sv | 140 ++++++++++++++
 tb/tb_voice_allocator.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared constants for the piano tone path: key indices, widths and allocator state encoding.
package piano_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = 13;
    localparam int AGE_W    = 3;

    typedef enum logic {
        ST_SONG = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic [KEY_W-1:0] KEY_C1  = 4'd0;
    localparam logic [KEY_W-1:0] KEY_CS1 = 4'd1;
    localparam logic [KEY_W-1:0] KEY_D1  = 4'd2;
    localparam logic [KEY_W-1:0] KEY_DS1 = 4'd3;
    localparam logic [KEY_W-1:0] KEY_E1  = 4'd4;
    localparam logic [KEY_W-1:0] KEY_F1  = 4'd5;
    localparam logic [KEY_W-1:0] KEY_FS1 = 4'd6;
    localparam logic [KEY_W-1:0] KEY_G1  = 4'd7;
    localparam logic [KEY_W-1:0] KEY_GS1 = 4'd8;
    localparam logic [KEY_W-1:0] KEY_A1  = 4'd9;
    localparam logic [KEY_W-1:0] KEY_AS1 = 4'd10;
    localparam logic [KEY_W-1:0] KEY_B1  = 4'd11;
    localparam logic [KEY_W-1:0] KEY_C2  = 4'd12;

    // Saturating increment used for voice ages.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] age,
                                                     input logic [AGE_W-1:0] age_max);
        logic [AGE_W-1:0] res;
        if (age >= age_max) begin
            res = age_max;
        end else begin
            res = age + 3'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key-side inputs and voice-side outputs of the polyphony allocator.
interface voice_allocator_if
    import piano_pkg::*;
#(
    parameter int NUM_VOICES = 2
) ();

    logic [NUM_KEYS-1:0]         key_value;
    logic [NUM_KEYS-1:0]         key_flag;
    logic                        stat;
    logic [NUM_VOICES-1:0]       voice_en;
    logic [KEY_W*NUM_VOICES-1:0] voice_key;
    logic                        alloc_pulse;
    logic                        steal_pulse;

    modport master (
        output key_value, key_flag, stat,
        input  voice_en, voice_key, alloc_pulse, steal_pulse
    );

    modport slave (
        input  key_value, key_flag, stat,
        output voice_en, voice_key, alloc_pulse, steal_pulse
    );

endinterface

// File: rtl/voice_allocator_lru.sv
// Per-voice saturating ages; presents the oldest voice (lowest index on ties) as the steal victim.
module voice_lru
    import piano_pkg::*;
#(
    parameter  int NUM_VOICES = 2,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic [VW-1:0]         alloc_idx,
    input  logic [NUM_VOICES-1:0] voice_en,
    output logic [VW-1:0]         victim
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [AGE_W-1:0] age_d [NUM_VOICES];
    logic [VW-1:0]    victim_q;
    logic [VW-1:0]    victim_d;
    logic [AGE_W-1:0] best_age_s;

    // Age update and victim search on the post-update ages, so the registered victim tracks age_q.
    always_comb begin
        for (int n = 0; n < NUM_VOICES; n++) begin
            age_d[n] = age_q[n];
        end
        if (clear) begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                age_d[n] = 3'd0;
            end
        end else if (alloc) begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                if (VW'(n) == alloc_idx) begin
                    age_d[n] = 3'd0;
                end else if (voice_en[n]) begin
                    age_d[n] = age_sat_inc(age_q[n], AGE_MAX);
                end else begin
                    age_d[n] = age_q[n];
                end
            end
        end else begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                age_d[n] = age_q[n];
            end
        end

        victim_d   = '0;
        best_age_s = age_d[0];
        for (int n = 1; n < NUM_VOICES; n++) begin
            if (age_d[n] > best_age_s) begin
                victim_d   = VW'(n);
                best_age_s = age_d[n];
            end else begin
                best_age_s = best_age_s;
            end
        end
    end

    // Age and victim registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                age_q[n] <= 3'd0;
            end
            victim_q <= '0;
        end else begin
            for (int n = 0; n < NUM_VOICES; n++) begin
                age_q[n] <= age_d[n];
            end
            victim_q <= victim_d;
        end
    end

    assign victim = victim_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: scans one key per cycle and binds pressed keys to voice channels,
// stealing the oldest voice when all are busy.
module voice_allocator
    import piano_pkg::*;
#(
    parameter  int NUM_VOICES = 2,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    voice_allocator_if.slave bus
);

    state_e                      state_q, state_d;
    logic [KEY_W-1:0]            scan_ptr_q, scan_ptr_d;
    logic [NUM_VOICES-1:0]       voice_en_q, voice_en_d;
    logic [KEY_W*NUM_VOICES-1:0] voice_key_q, voice_key_d;
    logic                        alloc_pulse_q, alloc_pulse_d;
    logic                        steal_pulse_q, steal_pulse_d;

    logic          pressed_s, released_s;
    logic          hit_s, free_s;
    logic [VW-1:0] hit_idx_s, free_idx_s, alloc_idx_s, victim_s;
    logic          lru_clear_s, lru_alloc_s;

    assign pressed_s  = bus.key_flag[scan_ptr_q] & ~bus.key_value[scan_ptr_q];
    assign released_s = bus.key_value[scan_ptr_q];

    // Priority encoders: lowest-index voice holding the scanned key, and lowest-index free voice.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        for (int n = NUM_VOICES - 1; n >= 0; n--) begin
            if (voice_en_q[n] && (voice_key_q[n*KEY_W +: KEY_W] == scan_ptr_q)) begin
                hit_s     = 1'b1;
                hit_idx_s = VW'(n);
            end else begin
                hit_s     = hit_s;
            end
            if (!voice_en_q[n]) begin
                free_s     = 1'b1;
                free_idx_s = VW'(n);
            end else begin
                free_s     = free_s;
            end
        end
    end

    // Next-state logic for the mode FSM, scan pointer and voice table.
    always_comb begin
        state_d       = state_q;
        scan_ptr_d    = scan_ptr_q;
        voice_en_d    = voice_en_q;
        voice_key_d   = voice_key_q;
        alloc_pulse_d = 1'b0;
        steal_pulse_d = 1'b0;
        lru_clear_s   = 1'b0;
        lru_alloc_s   = 1'b0;
        alloc_idx_s   = free_s ? free_idx_s : victim_s;

        if (bus.stat) begin
            state_d     = ST_SONG;
            scan_ptr_d  = KEY_C1;
            voice_en_d  = '0;
            voice_key_d = '0;
            lru_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_SONG: begin
                    state_d     = ST_SCAN;
                    scan_ptr_d  = KEY_C1;
                    voice_en_d  = '0;
                    voice_key_d = '0;
                    lru_clear_s = 1'b1;
                end
                ST_SCAN: begin
                    scan_ptr_d = (scan_ptr_q == KEY_C2) ? KEY_C1 : (scan_ptr_q + 4'd1);
                    if (pressed_s && !hit_s) begin
                        voice_en_d[alloc_idx_s]                       = 1'b1;
                        voice_key_d[int'(alloc_idx_s)*KEY_W +: KEY_W] = scan_ptr_q;
                        alloc_pulse_d                                 = 1'b1;
                        steal_pulse_d                                 = ~free_s;
                        lru_alloc_s                                   = 1'b1;
                    end else if (released_s && hit_s) begin
                        // The key field is left intact so the datapath can finish on the old pitch.
                        voice_en_d[hit_idx_s] = 1'b0;
                    end else begin
                        voice_en_d = voice_en_q;
                    end
                end
                default: begin
                    state_d     = ST_SONG;
                    scan_ptr_d  = KEY_C1;
                    voice_en_d  = '0;
                    voice_key_d = '0;
                    lru_clear_s = 1'b1;
                end
            endcase
        end
    end

    // FSM, scan counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_SONG;
            scan_ptr_q    <= KEY_C1;
            voice_en_q    <= '0;
            voice_key_q   <= '0;
            alloc_pulse_q <= 1'b0;
            steal_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_ptr_q    <= scan_ptr_d;
            voice_en_q    <= voice_en_d;
            voice_key_q   <= voice_key_d;
            alloc_pulse_q <= alloc_pulse_d;
            steal_pulse_q <= steal_pulse_d;
        end
    end

    voice_lru #(
        .NUM_VOICES (NUM_VOICES)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (lru_clear_s),
        .alloc     (lru_alloc_s),
        .alloc_idx (alloc_idx_s),
        .voice_en  (voice_en_q),
        .victim    (victim_s)
    );

    assign bus.voice_en    = voice_en_q;
    assign bus.voice_key   = voice_key_q;
    assign bus.alloc_pulse = alloc_pulse_q;
    assign bus.steal_pulse = steal_pulse_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed key scenarios push expected voice-table events,
// a negedge monitor pops one whenever an allocation pulses or voice_en changes.
module tb_voice_allocator;

    typedef struct packed {
        logic [1:0] en;
        logic [7:0] key;
        logic       alloc;
        logic       steal;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic mon_on;
    logic [1:0] prev_en;
    exp_t exp_q[$];
    exp_t exp_e;
    exp_t got_e;

    voice_allocator_if #(.NUM_VOICES(2)) vif ();

    voice_allocator #(.NUM_VOICES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor: every visible event must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_on) begin
            got_e = '{en: vif.voice_en, key: vif.voice_key, alloc: vif.alloc_pulse, steal: vif.steal_pulse};
            if (vif.alloc_pulse || vif.steal_pulse || (vif.voice_en != prev_en)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got en=%b key=%h alloc=%b steal=%b, none expected",
                             got_e.en, got_e.key, got_e.alloc, got_e.steal);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (got_e !== exp_e) begin
                        errors++;
                        $display("FAIL event got en=%b key=%h alloc=%b steal=%b want en=%b key=%h alloc=%b steal=%b",
                                 got_e.en, got_e.key, got_e.alloc, got_e.steal,
                                 exp_e.en, exp_e.key, exp_e.alloc, exp_e.steal);
                    end
                end
            end
            prev_en = vif.voice_en;
        end
    end

    task automatic push(input logic [1:0] en, input logic [7:0] key, input logic a, input logic s);
        exp_q.push_back('{en: en, key: key, alloc: a, steal: s});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending events after %0d cycles want 0", name, exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        mon_on        = 1'b0;
        prev_en       = 2'b00;
        rst_n         = 1'b0;
        vif.stat      = 1'b0;
        vif.key_value = 13'h1FFF;
        vif.key_flag  = 13'h1FFF;
        repeat (2) @(negedge clk);
        chk("rst_voice_en", 32'(vif.voice_en), 32'h0);
        chk("rst_voice_key", 32'(vif.voice_key), 32'h0);
        chk("rst_alloc", 32'(vif.alloc_pulse), 32'h0);
        chk("rst_steal", 32'(vif.steal_pulse), 32'h0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        repeat (30) @(negedge clk);
        chk("idle_voice_en", 32'(vif.voice_en), 32'h0);

        // Single key A1
        push(2'b01, 8'h09, 1'b1, 1'b0);
        vif.key_value[9] = 1'b0;
        wait_drain("single_press", 15);
        push(2'b00, 8'h09, 1'b0, 1'b0);
        vif.key_value[9] = 1'b1;
        wait_drain("single_release", 15);

        // Debounce gate on key 2
        vif.key_flag[2]  = 1'b0;
        vif.key_value[2] = 1'b0;
        repeat (40) @(negedge clk);
        chk("gate_idle", 32'(vif.voice_en), 32'h0);
        push(2'b01, 8'h02, 1'b1, 1'b0);
        vif.key_flag[2] = 1'b1;
        wait_drain("gate_release_flag", 15);
        push(2'b00, 8'h02, 1'b0, 1'b0);
        vif.key_value[2] = 1'b1;
        wait_drain("gate_key_up", 15);

        // Two keys: 0 then 4
        push(2'b01, 8'h00, 1'b1, 1'b0);
        vif.key_value[0] = 1'b0;
        wait_drain("two_key0", 15);
        push(2'b11, 8'h40, 1'b1, 1'b0);
        vif.key_value[4] = 1'b0;
        wait_drain("two_key4", 15);
        repeat (100) @(negedge clk);
        chk("hold_voice_en", 32'(vif.voice_en), 32'h3);
        chk("hold_voice_key", 32'(vif.voice_key), 32'h40);

        // Steal: key 0 goes pending (keeps voice 0, oldest), key 7 pressed
        push(2'b11, 8'h47, 1'b1, 1'b1);
        vif.key_flag[0] = 1'b0;
        vif.key_value[7] = 1'b0;
        wait_drain("steal", 15);
        chk("steal_voice1_key", 32'(vif.voice_key[7:4]), 32'h4);
        vif.key_value[0] = 1'b1;
        vif.key_flag[0]  = 1'b1;
        repeat (30) @(negedge clk);

        // Mode switch with keys 4 and 7 held
        push(2'b00, 8'h00, 1'b0, 1'b0);
        vif.stat = 1'b1;
        @(negedge clk);
        chk("mode_clear_next_cycle", 32'(vif.voice_en), 32'h0);
        wait_drain("mode_clear", 2);
        repeat (5) @(negedge clk);
        chk("song_idle", 32'(vif.voice_en), 32'h0);
        push(2'b01, 8'h04, 1'b1, 1'b0);
        push(2'b11, 8'h74, 1'b1, 1'b0);
        vif.stat = 1'b0;
        wait_drain("mode_realloc", 15);
        repeat (20) @(negedge clk);
        chk("final_voice_key", 32'(vif.voice_key), 32'h74);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
